// File: rtl/or21nand_pkg.sv
// Shared definitions for the or21nand pipeline: mode encoding and the cell function.
package or21nand_pkg;

    // Widest operand vector the shared cell function supports.
    localparam int unsigned MAX_W = 64;

    localparam logic MODE_OAI21 = 1'b0;
    localparam logic MODE_AOI21 = 1'b1;

    // Callers zero-extend operands to MAX_W and keep the low WIDTH bits of the result.
    function automatic logic [MAX_W-1:0] f_cell(
        input logic [MAX_W-1:0] a,
        input logic [MAX_W-1:0] b,
        input logic [MAX_W-1:0] c,
        input logic             mode
    );
        if (mode == MODE_AOI21) begin
            return ~((a & b) | c);
        end
        return ~((a | b) & c);
    endfunction

endpackage

// File: rtl/or21nand_pipe_slot.sv
// One elastic pipeline slot: a valid bit plus a result register with a combinational ready chain.
module or21nand_pipe_slot
    import or21nand_pkg::*;
#(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_valid,
    input  logic [WIDTH-1:0] i_data,
    input  logic             i_rdy_next,
    output logic             o_rdy,
    output logic             o_valid,
    output logic [WIDTH-1:0] o_data
);

    logic             r_valid;
    logic [WIDTH-1:0] r_data;

    assign o_rdy   = ~r_valid | i_rdy_next;
    assign o_valid = r_valid;
    assign o_data  = r_data;

    // Data loads only with a valid upstream so an empty pipe keeps its last result visible.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_valid <= 1'b0;
            r_data  <= '0;
        end else if (o_rdy) begin
            r_valid <= i_valid;
            if (i_valid) begin
                r_data <= i_data;
            end
        end
    end

endmodule

// File: rtl/or21nand_pipe.sv
// Registered WIDTH-bit OAI21/AOI21 vector with an elastic STAGES-deep pipeline
// and a saturating count of accepted all-zero results.
module or21nand_pipe
    import or21nand_pkg::*;
#(
    parameter int unsigned WIDTH  = 8,
    parameter int unsigned STAGES = 2,
    parameter int unsigned CNT_W  = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] i0,
    input  logic [WIDTH-1:0] i1,
    input  logic [WIDTH-1:0] i2,
    input  logic             mode,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] nq,
    input  logic             cnt_clr,
    output logic [CNT_W-1:0] zero_cnt
);

    logic [MAX_W-1:0] w_full;
    logic [STAGES:0]  w_valid;
    logic [WIDTH-1:0] w_data [STAGES+1];
    logic             w_rdy  [STAGES+1];
    logic             w_count;
    logic [CNT_W-1:0] r_cnt;

    assign w_full     = f_cell(MAX_W'(i0), MAX_W'(i1), MAX_W'(i2), mode);
    assign w_valid[0] = in_valid;
    assign w_data[0]  = w_full[WIDTH-1:0];
    assign w_rdy[STAGES] = out_ready;

    // Index 0 is the input side; index STAGES is the output of the last slot.
    for (genvar k = 0; k < STAGES; k++) begin : g_slot
        or21nand_pipe_slot #(
            .WIDTH(WIDTH)
        ) u_slot (
            .clk       (clk),
            .rst       (rst),
            .i_valid   (w_valid[k]),
            .i_data    (w_data[k]),
            .i_rdy_next(w_rdy[k+1]),
            .o_rdy     (w_rdy[k]),
            .o_valid   (w_valid[k+1]),
            .o_data    (w_data[k+1])
        );
    end

    assign in_ready  = w_rdy[0];
    assign out_valid = w_valid[STAGES];
    assign nq        = w_data[STAGES];

    assign w_count = out_valid & out_ready & (nq == '0);

    // Clear takes priority over a coinciding counting transfer.
    always_ff @(posedge clk) begin
        if (rst || cnt_clr) begin
            r_cnt <= '0;
        end else if (w_count && !(&r_cnt)) begin
            r_cnt <= r_cnt + CNT_W'(1);
        end
    end

    assign zero_cnt = r_cnt;

endmodule

// File: tb/tb_or21nand_pipe.sv
// Directed self-checking bench for or21nand_pipe with WIDTH=4, STAGES=2, CNT_W=4.
module tb_or21nand_pipe;

    logic       clk = 1'b0;
    logic       rst;
    logic       in_valid;
    logic       in_ready;
    logic [3:0] i0, i1, i2;
    logic       mode;
    logic       out_valid;
    logic       out_ready;
    logic [3:0] nq;
    logic       cnt_clr;
    logic [3:0] zero_cnt;

    int n_cmp = 0;
    int n_bad = 0;

    or21nand_pipe #(
        .WIDTH (4),
        .STAGES(2),
        .CNT_W (4)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .i0       (i0),
        .i1       (i1),
        .i2       (i2),
        .mode     (mode),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .nq       (nq),
        .cnt_clr  (cnt_clr),
        .zero_cnt (zero_cnt)
    );

    always #5 clk = ~clk;

    // Advance one rising edge; drive and sample 1 time unit after it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic m, input logic [3:0] a, input logic [3:0] b,
                         input logic [3:0] c);
        in_valid = 1'b1;
        mode = m;
        i0 = a;
        i1 = b;
        i2 = c;
    endtask

    task automatic test_reset();
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1; cnt_clr = 1'b0;
        mode = 1'b0; i0 = 4'h0; i1 = 4'h0; i2 = 4'h0;
        tick();
        tick();
        n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL reset_out_valid got %b want 0", out_valid); end
        n_cmp++; if (nq !== 4'h0) begin n_bad++; $display("FAIL reset_nq got %h want 0", nq); end
        n_cmp++; if (zero_cnt !== 4'h0) begin n_bad++; $display("FAIL reset_zero_cnt got %0d want 0", zero_cnt); end
        rst = 1'b0;
    endtask

    task automatic test_basic();
        drive(1'b0, 4'h3, 4'h4, 4'hF);
        #1;
        n_cmp++; if (in_ready !== 1'b1) begin n_bad++; $display("FAIL basic_in_ready got %b want 1", in_ready); end
        tick();
        in_valid = 1'b0;
        n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL basic_latency1 got %b want 0", out_valid); end
        tick();
        n_cmp++; if (out_valid !== 1'b1) begin n_bad++; $display("FAIL basic_out_valid got %b want 1", out_valid); end
        n_cmp++; if (nq !== 4'h8) begin n_bad++; $display("FAIL basic_nq got %h want 8", nq); end
        tick();
        n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL bubble_out_valid got %b want 0", out_valid); end
        n_cmp++; if (nq !== 4'h8) begin n_bad++; $display("FAIL bubble_nq_hold got %h want 8", nq); end
    endtask

    task automatic test_back_to_back();
        drive(1'b1, 4'hC, 4'hA, 4'h1);
        tick();
        drive(1'b0, 4'hC, 4'hA, 4'h1);
        tick();
        in_valid = 1'b0;
        n_cmp++; if (out_valid !== 1'b1 || nq !== 4'h6) begin
            n_bad++; $display("FAIL b2b_first got v=%b nq=%h want v=1 nq=6", out_valid, nq);
        end
        tick();
        n_cmp++; if (out_valid !== 1'b1 || nq !== 4'hF) begin
            n_bad++; $display("FAIL b2b_second got v=%b nq=%h want v=1 nq=f", out_valid, nq);
        end
        tick();
        n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL b2b_drain got %b want 0", out_valid); end
    endtask

    task automatic test_backpressure();
        out_ready = 1'b0;
        drive(1'b0, 4'h1, 4'h0, 4'hF);  // nq = e
        #1;
        n_cmp++; if (in_ready !== 1'b1) begin n_bad++; $display("FAIL bp_accept0 got %b want 1", in_ready); end
        tick();
        drive(1'b0, 4'h2, 4'h0, 4'hF);  // nq = d
        #1;
        n_cmp++; if (in_ready !== 1'b1) begin n_bad++; $display("FAIL bp_accept1 got %b want 1", in_ready); end
        tick();
        drive(1'b0, 4'h4, 4'h0, 4'hF);  // nq = b
        #1;
        n_cmp++; if (in_ready !== 1'b0) begin n_bad++; $display("FAIL bp_full got %b want 0", in_ready); end
        tick();
        n_cmp++; if (in_ready !== 1'b0) begin n_bad++; $display("FAIL bp_full_hold got %b want 0", in_ready); end
        n_cmp++; if (out_valid !== 1'b1 || nq !== 4'hE) begin
            n_bad++; $display("FAIL bp_stable got v=%b nq=%h want v=1 nq=e", out_valid, nq);
        end
        out_ready = 1'b1;
        #1;
        n_cmp++; if (in_ready !== 1'b1) begin n_bad++; $display("FAIL bp_release_ready got %b want 1", in_ready); end
        tick();
        in_valid = 1'b0;
        n_cmp++; if (out_valid !== 1'b1 || nq !== 4'hD) begin
            n_bad++; $display("FAIL bp_order1 got v=%b nq=%h want v=1 nq=d", out_valid, nq);
        end
        tick();
        n_cmp++; if (out_valid !== 1'b1 || nq !== 4'hB) begin
            n_bad++; $display("FAIL bp_order2 got v=%b nq=%h want v=1 nq=b", out_valid, nq);
        end
        tick();
        n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL bp_no_dup got %b want 0", out_valid); end
    endtask

    task automatic test_saturation();
        n_cmp++; if (zero_cnt !== 4'd0) begin n_bad++; $display("FAIL sat_start got %0d want 0", zero_cnt); end
        drive(1'b0, 4'hF, 4'h0, 4'hF);  // nq = 0
        for (int k = 1; k <= 20; k++) begin
            tick();
            if (k == 10) begin
                n_cmp++; if (zero_cnt !== 4'd8) begin n_bad++; $display("FAIL sat_mid got %0d want 8", zero_cnt); end
            end
        end
        in_valid = 1'b0;
        tick();
        tick();
        n_cmp++; if (zero_cnt !== 4'd15) begin n_bad++; $display("FAIL sat_final got %0d want 15", zero_cnt); end
        n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL sat_drain got %b want 0", out_valid); end
    endtask

    task automatic test_clear_collision();
        drive(1'b1, 4'h0, 4'h0, 4'hF);  // AOI21: nq = 0
        tick();
        in_valid = 1'b0;
        tick();
        n_cmp++; if (out_valid !== 1'b1 || nq !== 4'h0) begin
            n_bad++; $display("FAIL clr_setup got v=%b nq=%h want v=1 nq=0", out_valid, nq);
        end
        cnt_clr = 1'b1;
        tick();
        cnt_clr = 1'b0;
        n_cmp++; if (zero_cnt !== 4'd0) begin n_bad++; $display("FAIL clr_wins got %0d want 0", zero_cnt); end
        drive(1'b0, 4'h5, 4'hA, 4'hF);
        tick();
        in_valid = 1'b0;
        tick();
        tick();
        n_cmp++; if (zero_cnt !== 4'd1) begin n_bad++; $display("FAIL clr_recount got %0d want 1", zero_cnt); end
    endtask

    task automatic test_reset_midstream();
        out_ready = 1'b0;
        drive(1'b0, 4'hF, 4'hF, 4'hF);  // nq = 0
        tick();
        tick();
        n_cmp++; if (in_ready !== 1'b0 || out_valid !== 1'b1) begin
            n_bad++; $display("FAIL rst_fill got rdy=%b v=%b want rdy=0 v=1", in_ready, out_valid);
        end
        in_valid = 1'b0;
        rst = 1'b1;
        out_ready = 1'b1;
        tick();
        rst = 1'b0;
        n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL rst_mid_valid got %b want 0", out_valid); end
        n_cmp++; if (nq !== 4'h0) begin n_bad++; $display("FAIL rst_mid_nq got %h want 0", nq); end
        n_cmp++; if (zero_cnt !== 4'd0) begin n_bad++; $display("FAIL rst_mid_cnt got %0d want 0", zero_cnt); end
        tick();
        n_cmp++; if (out_valid !== 1'b0 || zero_cnt !== 4'd0) begin
            n_bad++; $display("FAIL rst_after got v=%b cnt=%0d want v=0 cnt=0", out_valid, zero_cnt);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_back_to_back();
        test_backpressure();
        test_saturation();
        test_clear_collision();
        test_reset_midstream();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
